// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first, through a single borrow flop.
// The parallel diff/borrow are registered at the last bit, then a one-cycle done pulse is raised.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_sr_reg, a_sr_next;
    logic [WIDTH-1:0] b_sr_reg, b_sr_next;
    logic [WIDTH-1:0] r_reg, r_next;
    logic             bw_reg, bw_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ser_bit_reg, ser_bit_next;
    logic             ser_valid_reg, ser_valid_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic             done_reg, done_next;

    logic [WIDTH-1:0] a_shift, b_shift;
    logic             x, y, d, bw_calc, last;

    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
            assign a_shift[gi] = a_sr_reg[gi+1];
            assign b_shift[gi] = b_sr_reg[gi+1];
        end
    endgenerate
    assign a_shift[WIDTH-1] = 1'b0;
    assign b_shift[WIDTH-1] = 1'b0;

    // Full-subtractor cell fed from the operand LSBs and the borrow flop.
    assign x       = a_sr_reg[0];
    assign y       = b_sr_reg[0];
    assign d       = x ^ y ^ bw_reg;
    assign bw_calc = (~x & y) | (~(x ^ y) & bw_reg);
    assign last    = (cnt_reg == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = SHIFT;
            SHIFT:   if (last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        a_sr_next      = a_sr_reg;
        b_sr_next      = b_sr_reg;
        r_next         = r_reg;
        bw_next        = bw_reg;
        cnt_next       = cnt_reg;
        ser_bit_next   = ser_bit_reg;
        ser_valid_next = ser_valid_reg;
        diff_next      = diff_reg;
        borrow_next    = borrow_reg;
        done_next      = 1'b0;
        case (state_reg)
            IDLE: begin
                ser_valid_next = 1'b0;
                if (start) begin
                    a_sr_next = a;
                    b_sr_next = b;
                    bw_next   = 1'b0;
                    cnt_next  = '0;
                    r_next    = '0;
                end
            end
            SHIFT: begin
                a_sr_next      = a_shift;
                b_sr_next      = b_shift;
                bw_next        = bw_calc;
                r_next         = {d, r_reg[WIDTH-1:1]};
                ser_bit_next   = d;
                ser_valid_next = 1'b1;
                cnt_next       = cnt_reg + CNT_W'(1);
                if (last) begin
                    diff_next   = {d, r_reg[WIDTH-1:1]};
                    borrow_next = bw_calc;
                    done_next   = 1'b1;
                end
            end
            DONE: begin
                ser_valid_next = 1'b0;
            end
            default: begin
                ser_valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_sr_reg      <= '0;
            b_sr_reg      <= '0;
            r_reg         <= '0;
            bw_reg        <= 1'b0;
            cnt_reg       <= '0;
            ser_bit_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            diff_reg      <= '0;
            borrow_reg    <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            a_sr_reg      <= a_sr_next;
            b_sr_reg      <= b_sr_next;
            r_reg         <= r_next;
            bw_reg        <= bw_next;
            cnt_reg       <= cnt_next;
            ser_bit_reg   <= ser_bit_next;
            ser_valid_reg <= ser_valid_next;
            diff_reg      <= diff_next;
            borrow_reg    <= borrow_next;
            done_reg      <= done_next;
        end
    end

    assign busy      = (state_reg != IDLE);
    assign ser_bit   = ser_bit_reg;
    assign ser_valid = ser_valid_reg;
    assign diff      = diff_reg;
    assign borrow    = borrow_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a cycle-level reference built from (a-b) arithmetic and an
// operation-age schedule, checked every cycle, plus directed literal cases and random operations.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, ser_bit, ser_valid, borrow, done;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit check_en = 0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .ser_bit   (ser_bit),
        .ser_valid (ser_valid),
        .diff      (diff),
        .borrow    (borrow),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: an accepted operation is tracked by its age in edges since acceptance.
    int           m_age = -1;
    logic [W-1:0] m_pend;
    logic         m_pend_bw;
    logic         m_busy, m_ser_bit, m_ser_valid, m_borrow, m_done;
    logic [W-1:0] m_diff;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_age = -1;
            m_busy = 0; m_ser_bit = 0; m_ser_valid = 0; m_diff = '0; m_borrow = 0; m_done = 0;
        end else begin
            if (m_age < 0) begin
                if (start) begin
                    m_age     = 0;
                    m_pend    = a - b;
                    m_pend_bw = (a < b);
                end
            end else begin
                m_age++;
            end
            if (m_age >= 0) begin
                m_busy      = (m_age <= W);
                m_ser_valid = (m_age >= 1 && m_age <= W);
                if (m_ser_valid) m_ser_bit = m_pend[m_age-1];
                m_done      = (m_age == W);
                if (m_age == W) begin
                    m_diff   = m_pend;
                    m_borrow = m_pend_bw;
                end
                if (m_age == W + 1) m_age = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            checks++;
            if ({busy, ser_bit, ser_valid, diff, borrow, done} !==
                {m_busy, m_ser_bit, m_ser_valid, m_diff, m_borrow, m_done}) begin
                errors++;
                $display("FAIL cycle %0d busy/sbit/sval/diff/bw/done got %b %b %b %h %b %b expected %b %b %b %h %b %b",
                         cyc, busy, ser_bit, ser_valid, diff, borrow, done,
                         m_busy, m_ser_bit, m_ser_valid, m_diff, m_borrow, m_done);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [W-1:0] exp_d,
                         input logic exp_bw);
        logic [W-1:0] bits;
        int           n;
        bit           got;
        @(posedge clk); #1;
        a = ta; b = tb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0; got = 0; bits = '0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ser_valid && n < W) begin
                bits[n] = ser_bit;
                n++;
            end
            if (done) got = 1;
        end
        check("done_seen", {31'd0, got}, 32'd1);
        check("diff", {28'd0, diff}, {28'd0, exp_d});
        check("borrow", {31'd0, borrow}, {31'd0, exp_bw});
        check("ser_bits", {24'd0, 4'(n), bits}, {24'd0, 4'(W), exp_d});
        $display("op a=%0d b=%0d diff=%0d borrow=%0d serial=%b", ta, tb, diff, borrow, bits);
    endtask

    initial begin
        int           t_done[3];
        int           nd;
        bit           idle_seen;
        logic [W-1:0] ra, rb;
        rst = 1'b0; start = 1'b0; a = '0; b = '0;
        @(posedge clk); #1;
        check_en = 1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("idle_after_reset", {27'd0, busy, ser_valid, done, borrow, 1'b0} | {28'd0, diff}, 32'd0);

        do_op(4'd5,  4'd3,  4'h2, 1'b0);
        do_op(4'd0,  4'd1,  4'hF, 1'b1);
        do_op(4'd3,  4'd2,  4'h1, 1'b0);
        do_op(4'd1,  4'd2,  4'hF, 1'b1);
        do_op(4'd0,  4'd0,  4'h0, 1'b0);
        do_op(4'd15, 4'd15, 4'h0, 1'b0);
        do_op(4'd15, 4'd0,  4'hF, 1'b0);

        // start pulses and operand changes during SHIFT must not disturb 5-3.
        @(posedge clk); #1;
        a = 4'd5; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd9; b = 4'd12;
        @(posedge clk); #1;
        start = 1'b0; a = 4'd1; b = 4'd1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 20 && nd == 0; i++) begin
            @(negedge clk);
            if (done) nd = 1;
        end
        check("ignored_start_done", nd, 1);
        check("ignored_start_diff", {28'd0, diff}, 32'd2);
        $display("op a=5 b=3 (disturbed) diff=%0d borrow=%0d", diff, borrow);

        // start held high: back-to-back operations every W+2 cycles.
        @(posedge clk); #1;
        a = 4'd7; b = 4'd2; start = 1'b1;
        nd = 0;
        for (int i = 0; i < 40 && nd < 3; i++) begin
            @(negedge clk);
            if (done) begin
                t_done[nd] = cyc;
                check("held_diff", {28'd0, diff}, 32'd5);
                $display("op a=7 b=2 (held start) diff=%0d borrow=%0d", diff, borrow);
                nd++;
            end
        end
        check("held_count", nd, 3);
        if (nd == 3) begin
            check("held_period0", t_done[1] - t_done[0], W + 2);
            check("held_period1", t_done[2] - t_done[1], W + 2);
        end
        @(posedge clk); #1;
        start = 1'b0;
        idle_seen = 0;
        for (int i = 0; i < 12 && !idle_seen; i++) begin
            @(negedge clk);
            if (!busy) idle_seen = 1;
        end
        check("held_drain_idle", {31'd0, idle_seen}, 32'd1);

        // Reset two cycles into an operation clears everything at once.
        @(posedge clk); #1;
        a = 4'd5; b = 4'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("reset_ser_bit_done_bw", {29'd0, ser_bit, done, borrow}, 32'd0);
        check("reset_diff", {28'd0, diff}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        do_op(4'd6, 4'd4, 4'h2, 1'b0);

        for (int k = 0; k < 40; k++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            do_op(ra, rb, ra - rb, ra < rb);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
